branch_predict_unit: RTL
========================

// Module: branch_predict_unit
// PURPOSE
//  Next-generation branch unit: EX-stage resolve (PC+Imm, PC+4, JAL/JALR target, taken decision) plus a
//  direct-mapped BTB with 2-bit saturating counters queried by IF. Emits per-fetch prediction and, at EX,
//  a one-cycle redirect on misprediction. Sits between IF (pc mux) and EX (ALU compare result).
// PARAMETERS
//  PC_W     9   width of architectural PC carried in pipeline; zero-extended to 32 bits
//  ENTRIES  16  BTB/BHT depth, power of 2, >=2; index = pc[$clog2(ENTRIES)+1:2]
//  TAG_W    PC_W-$clog2(ENTRIES)-2  tag = pc[PC_W-1:$clog2(ENTRIES)+2]; must be >=1
// PORTS
//  clk            in   1     clock, all state rising-edge
//  reset          in   1     synchronous, active-high
//  f_pc           in   PC_W  fetch PC (IF)
//  f_pred_taken   out  1     predicted taken for f_pc
//  f_pred_target  out  32    predicted target (valid when f_pred_taken)
//  ex_valid       in   1     EX holds a live instruction (0 on bubble/flush)
//  ex_pc          in   PC_W  PC of EX instruction
//  ex_imm         in   32    immediate
//  ex_branch      in   1     conditional branch
//  ex_jal         in   1     JAL
//  ex_jalr        in   1     JALR
//  ex_alu_result  in   32    bit0 = branch condition; full value = JALR sum
//  ex_pred_taken  in   1     f_pred_taken piped from IF with this instr
//  ex_pred_target in   32    f_pred_target piped from IF
//  pc_imm         out  32    jalr ? alu&~1 : {0,ex_pc}+imm
//  pc_four        out  32    {0,ex_pc}+4
//  redirect       out  1     mispredict; IF loads redirect_pc, IF/ID flushed
//  redirect_pc    out  32    correct next PC
// BEHAVIOUR
//  - Resolve (comb): taken = ex_jal | ex_jalr | (ex_branch & ex_alu_result[0]); target = pc_imm.
//    All adds mod 2^32. Non-control instr: taken=0.
//  - redirect = ex_valid & !reset & ((taken != ex_pred_taken) | (taken & ex_pred_target != target)).
//    redirect_pc = taken ? target : pc_four. When redirect=0, redirect_pc = pc_four.
//  - Entry: valid, tag, target[31:0], ctr[1:0]. Predict (comb, zero latency): hit = valid & tag match;
//    f_pred_taken = hit & ctr[1]; f_pred_target = hit ? target : 0.
//  - Update at clk edge when ex_valid & (ex_branch|ex_jal|ex_jalr):
//    miss & taken -> install: valid=1, tag, target, ctr=2'b10 (jal/jalr 2'b11).
//    miss & not taken -> no write.
//    hit -> ctr +1 if taken (sat 2'b11), -1 if not (sat 2'b00); target rewritten when taken.
//  - Same-cycle fetch read and update of same index: fetch sees pre-update contents (read-before-write).
//  - Aliasing: different tag on install overwrites entry unconditionally.
//  - Reset: all valid=0, ctr=2'b01, targets 0; outputs f_pred_taken=0, f_pred_target=0, redirect=0,
//    redirect_pc=pc_four. Reset asserted mid-stream drops any pending update that cycle.
//  - ex_valid=0: no update, redirect=0; pc_imm/pc_four still computed.
// CONFIGURATION
//  BPU_STATS_EN defined: adds outputs stat_branches[31:0] (+1 per updating EX instr) and
//    stat_mispred[31:0] (+1 per redirect); both clear on reset, wrap at 2^32.
//  Not defined: ports absent, no counters; prediction/redirect behaviour identical.
// TESTING
//  1 reset, f_pc=0x40 -> f_pred_taken=0, f_pred_target=0; all entries invalid.
//  2 BEQ at 0x40 imm=0x20 alu[0]=1, pred 0 -> redirect=1, redirect_pc=0x60; next cycle f_pc=0x40
//    -> taken=1, target=0x60 (ctr=10).
//  3 same branch resolves not-taken twice -> ctr 10->01->00; first redirect_pc=0x44; then prediction 0.
//  4 JALR alu=0x85 pred target 0x60 taken -> redirect=1, redirect_pc=0x84; entry target becomes 0x84.
//  5 update idx k and fetch idx k same cycle -> fetch returns old entry; next cycle new entry.
//  6 BPU_STATS_EN: 3 branches, 2 mispredicts -> stat_branches=3, stat_mispred=2; reset -> 0.

Source files
------------

// File: rtl/branch_predict_unit.sv
// rtl/branch_predict_unit.sv - EX-stage branch resolve plus direct-mapped BTB/BHT predictor
// Optional statistics counters are built when BPU_STATS_EN is defined.
module branch_predict_unit #(
  parameter int PC_W    = 9,
  parameter int ENTRIES = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [PC_W-1:0] f_pc,
  output logic            f_pred_taken,
  output logic [31:0]     f_pred_target,
  input  logic            ex_valid,
  input  logic [PC_W-1:0] ex_pc,
  input  logic [31:0]     ex_imm,
  input  logic            ex_branch,
  input  logic            ex_jal,
  input  logic            ex_jalr,
  input  logic [31:0]     ex_alu_result,
  input  logic            ex_pred_taken,
  input  logic [31:0]     ex_pred_target,
  output logic [31:0]     pc_imm,
  output logic [31:0]     pc_four,
  output logic            redirect,
  output logic [31:0]     redirect_pc
`ifdef BPU_STATS_EN
  ,
  output logic [31:0]     stat_branches,
  output logic [31:0]     stat_mispred
`endif
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = PC_W - IDX_W - 2;

  logic             valid_q  [ENTRIES];
  logic [TAG_W-1:0] tag_q    [ENTRIES];
  logic [31:0]      target_q [ENTRIES];
  logic [1:0]       ctr_q    [ENTRIES];

  logic [IDX_W-1:0] f_idx, ex_idx;
  logic [TAG_W-1:0] f_tag, ex_tag;
  logic             f_hit, ex_hit;
  logic [31:0]      ex_pc_ext;
  logic             taken, is_ctrl, upd_en;

  logic             wr_en_d;
  logic             wr_valid_d;
  logic [TAG_W-1:0] wr_tag_d;
  logic [31:0]      wr_target_d;
  logic [1:0]       wr_ctr_d;

  logic unused_bits;
  assign unused_bits = ^f_pc[1:0];

  assign f_idx  = f_pc[IDX_W+1:2];
  assign f_tag  = f_pc[PC_W-1:IDX_W+2];
  assign ex_idx = ex_pc[IDX_W+1:2];
  assign ex_tag = ex_pc[PC_W-1:IDX_W+2];

  // Fetch reads the registered arrays directly, so a same-cycle update is not visible yet.
  assign f_hit         = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
  assign f_pred_taken  = f_hit & ctr_q[f_idx][1];
  assign f_pred_target = f_hit ? target_q[f_idx] : 32'h0;

  assign ex_pc_ext = {{(32-PC_W){1'b0}}, ex_pc};
  assign pc_four   = ex_pc_ext + 32'd4;
  assign pc_imm    = ex_jalr ? (ex_alu_result & ~32'h1) : (ex_pc_ext + ex_imm);
  assign taken     = ex_jal | ex_jalr | (ex_branch & ex_alu_result[0]);
  assign is_ctrl   = ex_branch | ex_jal | ex_jalr;
  assign upd_en    = ex_valid & is_ctrl & ~reset;

  assign redirect    = ex_valid & ~reset &
                       ((taken != ex_pred_taken) | (taken & (ex_pred_target != pc_imm)));
  assign redirect_pc = (redirect & taken) ? pc_imm : pc_four;

  assign ex_hit = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);

  always_comb begin
    wr_en_d     = 1'b0;
    wr_valid_d  = valid_q[ex_idx];
    wr_tag_d    = tag_q[ex_idx];
    wr_target_d = target_q[ex_idx];
    wr_ctr_d    = ctr_q[ex_idx];
    if (upd_en) begin
      if (ex_hit) begin
        wr_en_d = 1'b1;
        if (taken) begin
          wr_target_d = pc_imm;
          if (ctr_q[ex_idx] != 2'b11) wr_ctr_d = ctr_q[ex_idx] + 2'b01;
        end else if (ctr_q[ex_idx] != 2'b00) begin
          wr_ctr_d = ctr_q[ex_idx] - 2'b01;
        end
      end else if (taken) begin
        // Install replaces whatever aliased entry held this index.
        wr_en_d     = 1'b1;
        wr_valid_d  = 1'b1;
        wr_tag_d    = ex_tag;
        wr_target_d = pc_imm;
        wr_ctr_d    = (ex_jal | ex_jalr) ? 2'b11 : 2'b10;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= 32'h0;
        ctr_q[i]    <= 2'b01;
      end
    end else if (wr_en_d) begin
      valid_q[ex_idx]  <= wr_valid_d;
      tag_q[ex_idx]    <= wr_tag_d;
      target_q[ex_idx] <= wr_target_d;
      ctr_q[ex_idx]    <= wr_ctr_d;
    end
  end

`ifdef BPU_STATS_EN
  logic [31:0] stat_branches_q, stat_branches_d;
  logic [31:0] stat_mispred_q, stat_mispred_d;

  always_comb begin
    stat_branches_d = stat_branches_q + (upd_en ? 32'd1 : 32'd0);
    stat_mispred_d  = stat_mispred_q + (redirect ? 32'd1 : 32'd0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stat_branches_q <= 32'h0;
      stat_mispred_q  <= 32'h0;
    end else begin
      stat_branches_q <= stat_branches_d;
      stat_mispred_q  <= stat_mispred_d;
    end
  end

  assign stat_branches = stat_branches_q;
  assign stat_mispred  = stat_mispred_q;
`endif

endmodule
